jtexterm_palread: RTL
=====================

JTEXTERM_PALREAD -- requirements
Module: jtexterm_palread

Interface
REQ-001 SHALL provide parameter BLANK_EN, default 1, meaning 1 = force RGB to zero while blanked, 0 = pass colour regardless of blanking.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-003 clk  input  1  system clock, also clocks the palette RAM read port.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 pxl_cen  input  1  pixel clock enable, one clk wide, period at least 4 clk.
REQ-006 LHBL  input  1  horizontal blank, active-low, aligned with pxl_idx.
REQ-007 LVBL  input  1  vertical blank, active-low, aligned with pxl_idx.
REQ-008 pxl_idx  input  9  palette entry index for the current pixel.
REQ-009 pal_addr  output  10  byte address to palette RAM read port.
REQ-010 pal_dout  input  8  palette RAM read data, valid 1 clk after pal_addr.
REQ-011 red, green, blue  output  5 each  registered colour.
REQ-012 LHBL_dly, LVBL_dly  output  1 each  blanking delayed to match the RGB outputs.
REQ-013 busy  output  1  high while a fetch is in progress.
REQ-014 overrun  output  1  sticky; set when pxl_cen arrives while busy.

Function
REQ-015 Palette entry n SHALL be two bytes: low byte at {n,0}, high byte at {n,1}; word = {high,low}.
REQ-016 Colour mapping SHALL be red=word[14:10], green=word[9:5], blue=word[4:0]; word[15] ignored.
REQ-017 On pxl_cen, the block SHALL latch pxl_idx, LHBL and LVBL into holding registers.
REQ-018 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-019 IDLE: on pxl_cen, go to LO with pal_addr={pxl_idx,0} driven in the same cycle as LO.
REQ-020 LO: drive pal_addr={idx,1}; go to HI.
REQ-021 HI: capture pal_dout as low byte; go to DONE.
REQ-022 DONE: capture pal_dout as high byte; update red/green/blue, LHBL_dly and LVBL_dly from the holding registers; go to IDLE.
REQ-023 Latency SHALL be exactly 4 clk from the pxl_cen cycle to the updated outputs being visible.
REQ-024 busy SHALL be high in LO, HI and DONE, and low in IDLE.
REQ-025 A pxl_cen arriving in LO, HI or DONE SHALL do the following:
- set overrun;
- relatch pxl_idx and the blanking inputs;
- restart the fetch at LO;
- RGB and blanking outputs keep their previous values.
REQ-026 If BLANK_EN=1 and either held blank is low at DONE, red/green/blue SHALL be loaded with 0; the delayed blanks still update.
REQ-027 pal_addr SHALL be held at its last value in IDLE.
REQ-028 Index 511 SHALL address bytes 1022/1023 with no wrap into index 0.
REQ-029 Outputs SHALL change only in DONE or on reset.

Reset
REQ-030 rst high SHALL asynchronously force the following:
- FSM to IDLE;
- red/green/blue to 0;
- LHBL_dly and LVBL_dly to 0;
- pal_addr to 0;
- busy to 0;
- overrun to 0;
- holding registers to 0.
REQ-031 Reset asserted mid-fetch SHALL abandon the fetch; the first pxl_cen after release starts a clean fetch.
REQ-032 Only rst clears overrun.

Verification
REQ-033 Mixed-colour fetch:
- stimulus: RAM[0x0A]=0xE0, RAM[0x0B]=0x7F, pxl_idx=5, blanks=1, pxl_cen;
- response: pal_addr sequence 0x0A then 0x0B;
- response: after 4 clk red=0x1F, green=0x1F, blue=0x00;
- response: busy high for 3 clk.
REQ-034 Blanking:
- stimulus: same entry, LHBL=0, BLANK_EN=1;
- response: RGB=0, LHBL_dly=0 after 4 clk;
- stimulus: same with BLANK_EN=0;
- response: red=0x1F, green=0x1F, blue=0x00.
REQ-035 Top index:
- stimulus: pxl_idx=511, RAM[1022]=0x1F, RAM[1023]=0x00;
- response: pal_addr 0x3FE then 0x3FF;
- response: red=0, green=0, blue=0x1F.
REQ-036 Overrun:
- stimulus: second pxl_cen 2 clk after the first, with a new index 3;
- response: overrun=1;
- response: fetch of addresses 6/7 completes 4 clk after the second pxl_cen;
- response: prior RGB held until then.
REQ-037 Reset mid-fetch:
- stimulus: rst pulse in state HI;
- response: all outputs 0 immediately and FSM in IDLE;
- response: the next pxl_cen fetch produces the correct colour after 4 clk.
REQ-038 Back-to-back pixels:
- stimulus: pxl_cen every 4 clk over 16 indices with random RAM;
- response: each RGB matches the reference word mapping;
- response: overrun stays 0.

Source files
------------

// File: rtl/jtexterm_palread_if.sv
`default_nettype none
// ============================================================================
// jtexterm_palread_if
// Pixel-side and palette-RAM-side signals of the palette reader.
// Revision: 1.0
// ============================================================================
interface jtexterm_palread_if;
  logic       pxl_cen;
  logic       LHBL;
  logic       LVBL;
  logic [8:0] pxl_idx;
  logic [9:0] pal_addr;
  logic [7:0] pal_dout;
  logic [4:0] red;
  logic [4:0] green;
  logic [4:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;
  logic       busy;
  logic       overrun;

  // master: video timing and palette RAM side
  modport master (
    output pxl_cen, LHBL, LVBL, pxl_idx, pal_dout,
    input  pal_addr, red, green, blue, LHBL_dly, LVBL_dly, busy, overrun
  );

  // slave: the palette reader itself
  modport slave (
    input  pxl_cen, LHBL, LVBL, pxl_idx, pal_dout,
    output pal_addr, red, green, blue, LHBL_dly, LVBL_dly, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/jtexterm_palread.sv
`default_nettype none
// ============================================================================
// jtexterm_palread
// Fetches a 16-bit xRGB555 palette word as two bytes per pixel and registers
// the colour together with the delayed blanking signals.
// Revision: 1.0
// ============================================================================
module jtexterm_palread #(
  parameter int unsigned BLANK_EN = 1
) (
  input  wire                 clk,
  input  wire                 rst,
  jtexterm_palread_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [8:0] r_idx;
  logic       r_lhbl;
  logic       r_lvbl;
  logic [7:0] r_lo;
  logic [9:0] r_pal_addr;
  logic [4:0] r_red;
  logic [4:0] r_green;
  logic [4:0] r_blue;
  logic       r_lhbl_dly;
  logic       r_lvbl_dly;
  logic       r_busy;
  logic       r_overrun;

  logic       w_blank;
  logic [4:0] w_red;
  logic [4:0] w_green;
  logic [4:0] w_blue;

  // pal_dout holds the high byte during DONE; bit 7 (word[15]) is unused
  assign w_red   = bus.pal_dout[6:2];
  assign w_green = {bus.pal_dout[1:0], r_lo[7:5]};
  assign w_blue  = r_lo[4:0];
  assign w_blank = (BLANK_EN != 0) && !(r_lhbl && r_lvbl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 9'd0;
      r_lhbl     <= 1'b0;
      r_lvbl     <= 1'b0;
      r_lo       <= 8'd0;
      r_pal_addr <= 10'd0;
      r_red      <= 5'd0;
      r_green    <= 5'd0;
      r_blue     <= 5'd0;
      r_lhbl_dly <= 1'b0;
      r_lvbl_dly <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (bus.pxl_cen) begin
      // a new pixel always (re)starts the fetch, even over one in flight
      r_idx      <= bus.pxl_idx;
      r_lhbl     <= bus.LHBL;
      r_lvbl     <= bus.LVBL;
      r_pal_addr <= {bus.pxl_idx, 1'b0};
      r_state    <= ST_LO;
      r_busy     <= 1'b1;
      if (r_state != ST_IDLE) begin
        r_overrun <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_LO: begin
          r_pal_addr <= {r_idx, 1'b1};
          r_state    <= ST_HI;
        end
        ST_HI: begin
          r_lo    <= bus.pal_dout;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_red      <= w_blank ? 5'd0 : w_red;
          r_green    <= w_blank ? 5'd0 : w_green;
          r_blue     <= w_blank ? 5'd0 : w_blue;
          r_lhbl_dly <= r_lhbl;
          r_lvbl_dly <= r_lvbl;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pal_addr = r_pal_addr;
  assign bus.red      = r_red;
  assign bus.green    = r_green;
  assign bus.blue     = r_blue;
  assign bus.LHBL_dly = r_lhbl_dly;
  assign bus.LVBL_dly = r_lvbl_dly;
  assign bus.busy     = r_busy;
  assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire
